pulse_train_gen: RTL and testbench

//   Programmable pulse-train source feeding the pulse delay line. On a start request it

---
 rtl/pulse_pkg.sv | 18 +
 rtl/pulse_phase_cnt.sv | 27 ++
 rtl/pulse_train_gen.sv | 163 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared state encoding and default counter width for the pulse-train generator.
package pulse_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_HIGH = HIGH,
    S_LOW  = LOW,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/pulse_phase_cnt.sv
// Loadable down-counter timing the HIGH and LOW phases; zero marks the last cycle of a phase.
module pulse_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: N pulses of W high cycles every P cycles, or continuous.
import pulse_pkg::*;

module pulse_train_gen #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_num,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

  state_t           state_reg;
  logic [CNT_W-1:0] w_reg;
  logic [CNT_W-1:0] low_reg;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] pulse_cnt_reg;
  logic             pulse_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [CNT_W-1:0] w_next;
  logic [CNT_W-1:0] p_next;
  logic [CNT_W-1:0] low_next;
  logic             accept;
  logic             more_pulses;
  logic             ph_load;
  logic [CNT_W-1:0] ph_load_val;
  logic             ph_dec;
  logic             ph_zero;

  // Clamp so the high phase is at least one cycle and the low phase is at least one cycle;
  // an all-ones width would overflow W+1, so it is pulled down by one instead.
  always_comb begin
    w_next = (cfg_width == '0) ? ONE : cfg_width;
    p_next = cfg_period;
    if (cfg_width == ONES) begin
      w_next = ONES - ONE;
      p_next = ONES;
    end else if (cfg_period <= w_next) begin
      p_next = w_next + ONE;
    end
    low_next = p_next - w_next;
  end

  assign accept      = (state_reg == S_IDLE) && start && !stop;
  assign more_pulses = (num_reg == '0) || (pulse_cnt_reg < num_reg);

  always_comb begin
    ph_load     = 1'b0;
    ph_load_val = '0;
    ph_dec      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          ph_load     = 1'b1;
          ph_load_val = w_next - ONE;
        end
      end
      S_HIGH: begin
        if (!stop) begin
          if (ph_zero) begin
            ph_load     = 1'b1;
            ph_load_val = low_reg - ONE;
          end else begin
            ph_dec = 1'b1;
          end
        end
      end
      S_LOW: begin
        if (!stop) begin
          if (ph_zero) begin
            ph_load     = more_pulses;
            ph_load_val = w_reg - ONE;
          end else begin
            ph_dec = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  pulse_phase_cnt #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ph_load),
    .load_val (ph_load_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      w_reg         <= '0;
      low_reg       <= '0;
      num_reg       <= '0;
      pulse_cnt_reg <= '0;
      pulse_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg     <= S_HIGH;
            w_reg         <= w_next;
            low_reg       <= low_next;
            num_reg       <= cfg_num;
            pulse_cnt_reg <= ONE;
            pulse_reg     <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        S_HIGH: begin
          if (stop) begin
            state_reg <= S_DONE;
            pulse_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (ph_zero) begin
            state_reg <= S_LOW;
            pulse_reg <= 1'b0;
          end
        end
        S_LOW: begin
          if (stop || (ph_zero && !more_pulses)) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (ph_zero) begin
            state_reg <= S_HIGH;
            pulse_reg <= 1'b1;
            if (pulse_cnt_reg != ONES) begin
              pulse_cnt_reg <= pulse_cnt_reg + ONE;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign pulse     = pulse_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign pulse_cnt = pulse_cnt_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed and randomized trains checked against an arithmetic waveform model.
module tb_pulse_train_gen;

  localparam int CNT_W = 6;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_num;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  int checks;
  int errors;
  int last_cnt;

  pulse_train_gen #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_num    (cfg_num),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input int ep, input int eb,
                         input int ed, input int ec);
    string s;
    s = $sformatf("%s t=%0d", tag, t);
    chk({s, " pulse"}, 32'(pulse), 32'(ep));
    chk({s, " busy"}, 32'(busy), 32'(eb));
    chk({s, " done"}, 32'(done), 32'(ed));
    chk({s, " cnt"}, 32'(pulse_cnt), 32'(ec));
  endtask

  // Launch a train and check every cycle until one cycle past the done strobe.
  // stop_at: stop sampled on the edge that closes cycle stop_at-1 (0 = never).
  // start_at: re-assert start for one cycle mid-train (-1 = never).
  task automatic run_train(input string tag, input int w, input int p, input int n,
                           input int stop_at, input int start_at, input bit chg_cfg);
    int wm, pm, e, ep, eb, ed, ec, cnt_end;
    wm = (w == 0) ? 1 : w;
    if (w == MAXV) begin
      wm = MAXV - 1;
      pm = MAXV;
    end else begin
      pm = (p > wm) ? p : wm + 1;
    end
    if (n == 0) e = stop_at;
    else if (stop_at > 0 && stop_at < n * pm) e = stop_at;
    else e = n * pm;
    cnt_end = ((e - 1) / pm + 1 > MAXV) ? MAXV : (e - 1) / pm + 1;

    cfg_width  = CNT_W'(w);
    cfg_period = CNT_W'(p);
    cfg_num    = CNT_W'(n);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= e + 1; t++) begin
      if (t < e) begin
        ep = ((t % pm) < wm) ? 1 : 0;
        eb = 1;
        ed = 0;
        ec = (t / pm + 1 > MAXV) ? MAXV : t / pm + 1;
      end else begin
        ep = 0;
        eb = 0;
        ed = (t == e) ? 1 : 0;
        ec = cnt_end;
      end
      chk_all(tag, t, ep, eb, ed, ec);
      stop  = (stop_at > 0 && t == stop_at - 1);
      start = (t == start_at);
      if (chg_cfg) begin
        cfg_width  = CNT_W'($urandom_range(0, MAXV));
        cfg_period = CNT_W'($urandom_range(0, MAXV));
        cfg_num    = CNT_W'($urandom_range(0, MAXV));
      end
      @(negedge clk);
    end
    stop  = 1'b0;
    start = 1'b0;
    last_cnt = cnt_end;
    $display("train %s W=%0d P=%0d N=%0d stop_at=%0d: end at t=%0d cnt=%0d",
             tag, w, p, n, stop_at, e, cnt_end);
  endtask

  initial begin
    int w, p, n, s;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_width = '0;
    cfg_period = '0;
    cfg_num = '0;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 0, 0, 0, 0, 0);

    run_train("basic", 2, 5, 3, 0, -1, 1'b0);
    run_train("clamp0", 0, 0, 2, 0, -1, 1'b0);
    run_train("cont_stop", 1, 3, 0, 10, -1, 1'b0);

    // start and stop together in IDLE must not launch anything
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk_all("start_stop_idle", t, 0, 0, 0, last_cnt);
      @(negedge clk);
    end
    $display("start+stop in idle: no train expected");

    run_train("start_busy", 2, 4, 3, 0, 5, 1'b0);
    run_train("start_in_done", 1, 2, 2, 0, 4, 1'b0);
    run_train("cfg_change", 3, 4, 2, 0, -1, 1'b1);
    run_train("stop_high", 3, 6, 4, 8, -1, 1'b0);
    run_train("width_max", MAXV, 5, 1, 0, -1, 1'b0);
    run_train("saturate", 1, 2, 0, 2 * MAXV + 10, -1, 1'b0);

    // asynchronous reset in the middle of a train
    cfg_width  = CNT_W'(4);
    cfg_period = CNT_W'(8);
    cfg_num    = CNT_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk_all("pre_rst", t, ((t % 8) < 4) ? 1 : 0, 1, 0, 1);
      @(negedge clk);
    end
    #2 rstn = 1'b0;
    #1;
    chk_all("mid_rst", 6, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk_all("after_rst", t, 0, 0, 0, 0);
    end
    $display("reset mid-train: outputs cleared, no done");

    for (int i = 0; i < 20; i++) begin
      w = int'($urandom_range(0, 6));
      p = int'($urandom_range(0, 10));
      n = int'($urandom_range(0, 4));
      s = (n == 0 || $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_train($sformatf("rand%0d", i), w, p, n, s, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
